// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types, defaults and width helpers for the debouncer
package debounce_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_WAIT,
        RPT_RUN
    } rpt_state_t;

    localparam int DEF_CHANNELS      = 4;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 131072;
    localparam int DEF_REPEAT_DELAY  = 50000000;
    localparam int DEF_REPEAT_PERIOD = 10000000;

    // Bits needed to hold values 0..max_count
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one channel: synchroniser, stability filter, edge pulses, auto-repeat
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic repeat_en,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic repeat_pulse
);

    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [CW-1:0] CNT_LAST    = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CW-1:0]          cnt;
    logic [RW-1:0]          rcnt;
    rpt_state_t             state;
    logic                   accept;
    logic                   rise_evt;
    logic                   fall_evt;

    assign s        = sync[SYNC_STAGES-1];
    // The differing sample that completes the stable run is accepted on this edge
    assign accept   = (s != level) && (cnt == CNT_LAST);
    assign rise_evt = accept & s;
    assign fall_evt = accept & ~s;

    // Shift the raw input through the synchroniser chain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    // Count consecutive differing samples; accept the new level and pulse once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (accept) begin
                cnt        <= '0;
                level      <= s;
                rise_pulse <= s;
                fall_pulse <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Auto-repeat: first pulse after REPEAT_DELAY, then every REPEAT_PERIOD while held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RPT_IDLE;
            rcnt         <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= 1'b0;
            case (state)
                RPT_IDLE: begin
                    if (rise_evt && repeat_en) begin
                        state <= RPT_WAIT;
                        rcnt  <= '0;
                    end
                end
                RPT_WAIT: begin
                    if (fall_evt || !repeat_en) begin
                        state <= RPT_IDLE;
                        rcnt  <= '0;
                    end else if (rcnt == DELAY_LAST) begin
                        state        <= RPT_RUN;
                        rcnt         <= '0;
                        repeat_pulse <= 1'b1;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                RPT_RUN: begin
                    if (fall_evt || !repeat_en) begin
                        state <= RPT_IDLE;
                        rcnt  <= '0;
                    end else if (rcnt == PERIOD_LAST) begin
                        rcnt         <= '0;
                        repeat_pulse <= 1'b1;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: begin
                    state <= RPT_IDLE;
                    rcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - array of independent debounce channels
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = DEF_CHANNELS,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] raw_in,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] repeat_pulse
);

    // One self-contained channel per input bit
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .raw         (raw_in[i]),
            .repeat_en   (repeat_en[i]),
            .level       (level[i]),
            .rise_pulse  (rise_pulse[i]),
            .fall_pulse  (fall_pulse[i]),
            .repeat_pulse(repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - scoreboard bench for debounce_multi against a history-based model
module tb_debounce_multi;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int SC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] raw_in;
    logic [CH-1:0] repeat_en;
    logic [CH-1:0] level;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic [CH-1:0] repeat_pulse;

    always #5 clk = ~clk;

    debounce_multi #(
        .CHANNELS     (CH),
        .SYNC_STAGES  (SS),
        .STABLE_CYCLES(SC),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw_in      (raw_in),
        .repeat_en   (repeat_en),
        .level       (level),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .repeat_pulse(repeat_pulse)
    );

    logic [15:0]   exp_q[$];
    logic [CH-1:0] eff[$];
    int            t = 0;
    int            lvl[CH];
    int            last_chg[CH];
    int            armed[CH];
    int            rise_t[CH];
    int            n_checks = 0;
    int            n_pass = 0;

    // Synchronised sample seen at edge k is the raw value present SS edges earlier
    function automatic int s_at(input int k, input int ch);
        logic [CH-1:0] v;
        if (k < 0) return 0;
        v = eff[k];
        return int'(v[ch]);
    endfunction

    task automatic step(input logic [CH-1:0] r, input logic [CH-1:0] en, input logic rn);
        logic [CH-1:0] l, ri, fa, rp;
        int            d;
        logic          ok;
        raw_in    = r;
        repeat_en = en;
        rst_n     = rn;
        @(posedge clk);
        ri = '0; fa = '0; rp = '0; l = '0;
        if (!rn) begin
            eff.push_back('0);
            if (t > 0) eff[t-1] = '0;
            for (int ch = 0; ch < CH; ch++) begin
                lvl[ch]      = 0;
                last_chg[ch] = t;
                armed[ch]    = 0;
            end
        end else begin
            eff.push_back(r);
            for (int ch = 0; ch < CH; ch++) begin
                ok = (last_chg[ch] <= t - SC);
                for (int j = 0; j < SC; j++)
                    if (s_at(t - SS - j, ch) == lvl[ch]) ok = 1'b0;
                if (ok) begin
                    lvl[ch]      = 1 - lvl[ch];
                    last_chg[ch] = t;
                    if (lvl[ch] == 1) ri[ch] = 1'b1;
                    else              fa[ch] = 1'b1;
                end
                if (armed[ch] != 0) begin
                    if (fa[ch] || !en[ch]) begin
                        armed[ch] = 0;
                    end else begin
                        d = t - rise_t[ch];
                        if (d == RD || (d > RD && (d - RD) % RP == 0)) rp[ch] = 1'b1;
                    end
                end
                if (ri[ch] && en[ch]) begin
                    armed[ch]  = 1;
                    rise_t[ch] = t;
                end
            end
        end
        for (int ch = 0; ch < CH; ch++) l[ch] = (lvl[ch] != 0);
        exp_q.push_back({l, ri, fa, rp});
        t++;
        #2;
    endtask

    task automatic hold(input logic [CH-1:0] r, input logic [CH-1:0] en, input int n);
        for (int i = 0; i < n; i++) step(r, en, 1'b1);
    endtask

    // Monitor: every cycle the DUT presents a fresh output vector
    always @(negedge clk) begin
        logic [15:0] e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {level, rise_pulse, fall_pulse, repeat_pulse};
            n_checks++;
            if (g === e) n_pass++;
            else $display("FAIL outputs t=%0t lvl/rise/fall/rpt got=%h want=%h", $time, g, e);
        end
    end

    initial begin
        logic [CH-1:0] r, e;
        logic [10:0]   bpat;
        for (int ch = 0; ch < CH; ch++) begin
            lvl[ch] = 0; last_chg[ch] = 0; armed[ch] = 0; rise_t[ch] = 0;
        end
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);
        hold('0, '0, 5);

        // Clean press on ch0
        hold(4'b0001, '0, 20);
        // Release, then bounce pattern into a final stable run
        hold(4'b0000, '0, 10);
        bpat = 11'b11110110111;
        for (int i = 0; i < 11; i++) step({3'b000, bpat[i]}, '0, 1'b1);
        hold(4'b0001, '0, 10);
        // Release, then short high glitches that must not register
        hold(4'b0000, '0, 10);
        for (int k = 0; k < 3; k++) begin
            hold(4'b0001, '0, 3);
            hold(4'b0000, '0, 4);
        end
        // Press and release with 3-cycle low glitches
        hold(4'b0001, '0, 10);
        for (int k = 0; k < 3; k++) begin
            hold(4'b0000, '0, 3);
            hold(4'b0001, '0, 4);
        end
        hold(4'b0000, '0, 10);

        // Auto-repeat on ch1, release, then drop repeat_en mid-run
        hold(4'b0010, 4'b0010, 40);
        hold(4'b0000, 4'b0010, 15);
        hold(4'b0010, 4'b0010, 25);
        hold(4'b0010, 4'b0000, 6);
        hold(4'b0010, 4'b0010, 10);
        hold(4'b0000, 4'b0010, 10);

        // Reset mid-repeat with raw held high
        hold(4'b0010, 4'b0010, 18);
        step(4'b0010, 4'b0010, 1'b0);
        step(4'b0010, 4'b0010, 1'b0);
        hold(4'b0010, 4'b0010, 30);
        hold(4'b0000, 4'b0010, 10);

        // All channels together, then staggered ch0/ch3
        hold(4'b1111, 4'b0000, 12);
        hold(4'b0000, 4'b0000, 10);
        hold(4'b0001, 4'b1001, 2);
        hold(4'b1001, 4'b1001, 20);
        hold(4'b1000, 4'b1001, 3);
        hold(4'b0000, 4'b1001, 12);

        // Randomised traffic with occasional resets
        r = '0;
        e = 4'b1111;
        for (int c = 0; c < 500; c++) begin
            for (int ch = 0; ch < CH; ch++)
                if ($urandom_range(0, 5) == 0) r[ch] = ~r[ch];
            if ($urandom_range(0, 40) == 0) e = CH'($urandom);
            step(r, e, ($urandom_range(0, 199) != 0));
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain leftover=%0d want=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
